// File: rtl/audio_pkg.sv
// Shared recorder types and widths: arbiter state/port enums, clip memory geometry.
// Used by the clip memory arbiter and the recorder controller datapath.
package audio_pkg;

   localparam int AUDIO_ADDR_W = 17;
   localparam int AUDIO_DATA_W = 8;
   localparam int CLIP_DEPTH   = 100000;

   typedef enum logic [1:0] {ARB_IDLE, ARB_WRITE, ARB_READ, ARB_READ_WAIT} arb_state_t;
   typedef enum logic {PORT_WR, PORT_RD} arb_port_t;

   function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
      return addr >= depth;
   endfunction

endpackage

// File: rtl/clip_memory_arbiter_rr_picker2.sv
// Two-way round-robin picker: combinational one-hot grant plus the pointer to use next.
// Pointer always moves to the side that was not granted; unchanged when nobody asks.
module rr_picker2
   import audio_pkg::*;
(
   input  logic       i_wr_req,
   input  logic       i_rd_req,
   input  logic       i_ptr,
   output logic [1:0] o_grant,
   output logic       o_ptr_nxt
);

   always_comb begin
      o_grant   = 2'b00;
      o_ptr_nxt = i_ptr;
      if (i_wr_req && i_rd_req) begin
         o_grant   = (i_ptr == PORT_WR) ? 2'b01 : 2'b10;
         o_ptr_nxt = ~i_ptr;
      end else if (i_wr_req) begin
         o_grant   = 2'b01;
         o_ptr_nxt = PORT_RD;
      end else if (i_rd_req) begin
         o_grant   = 2'b10;
         o_ptr_nxt = PORT_WR;
      end
   end

endmodule

// File: rtl/clip_memory_arbiter.sv
// Round-robin arbiter sharing the clip memory between record (write) and playback (read); ack after 1 cycle (write) or 2+READ_LATENCY (read).
// Requesters hold req until ack; ARB_WAIT_STATS_EN adds saturating wait-cycle counters with stats_clr_i.
module clip_memory_arbiter
   import audio_pkg::*;
#(
   parameter int ADDR_W       = AUDIO_ADDR_W,
   parameter int DATA_W       = AUDIO_DATA_W,
   parameter int DEPTH        = CLIP_DEPTH,
   parameter int READ_LATENCY = 1
)(
   input  logic              clock_i,
   input  logic              reset_i,
`ifdef ARB_WAIT_STATS_EN
   input  logic              stats_clr_i,
   output logic [15:0]       wr_wait_cnt_o,
   output logic [15:0]       rd_wait_cnt_o,
`endif
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic              wr_bank_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_ack_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              rd_bank_i,
   output logic              rd_ack_o,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              err_o,
   output logic              mem_en_o,
   output logic              mem_rw_o,
   output logic              mem_bank_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   arb_state_t        r_state, w_state_nxt;
   arb_port_t         r_ptr;
   logic [1:0]        w_grant;
   logic              w_ptr_nxt;
   logic [2:0]        r_lat_cnt;
   logic              r_oor;
   logic              w_wr_oor, w_rd_oor, w_rd_capture;

   logic              r_wr_ack, r_rd_ack, r_rd_valid, r_err, r_mem_en, r_mem_rw, r_mem_bank;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata, r_rd_data;
   logic              w_wr_ack_d, w_rd_ack_d, w_rd_valid_d, w_err_d, w_mem_en_d, w_mem_rw_d, w_mem_bank_d;
   logic [ADDR_W-1:0] w_mem_addr_d;
   logic [DATA_W-1:0] w_mem_wdata_d, w_rd_data_d;

   rr_picker2 u_picker (
      .i_wr_req  (wr_req_i),
      .i_rd_req  (rd_req_i),
      .i_ptr     (r_ptr),
      .o_grant   (w_grant),
      .o_ptr_nxt (w_ptr_nxt)
   );

   assign w_wr_oor     = addr_oor(32'(wr_addr_i), 32'(DEPTH));
   assign w_rd_oor     = addr_oor(32'(rd_addr_i), 32'(DEPTH));
   // Last wait cycle: mem_rdata_i is valid READ_LATENCY cycles after the strobe.
   assign w_rd_capture = (r_state == ARB_READ_WAIT) && (r_lat_cnt == 3'(READ_LATENCY - 1));

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state     <= ARB_IDLE;
         r_ptr       <= PORT_WR;
         r_lat_cnt   <= '0;
         r_oor       <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_rd_ack    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_err       <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_bank  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ARB_IDLE && w_grant != 2'b00) begin
            r_ptr <= arb_port_t'(w_ptr_nxt);
            r_oor <= w_grant[0] ? w_wr_oor : w_rd_oor;
         end
         r_lat_cnt   <= (r_state == ARB_READ_WAIT) ? r_lat_cnt + 3'd1 : 3'd0;
         r_wr_ack    <= w_wr_ack_d;
         r_rd_ack    <= w_rd_ack_d;
         r_rd_valid  <= w_rd_valid_d;
         r_rd_data   <= w_rd_data_d;
         r_err       <= w_err_d;
         r_mem_en    <= w_mem_en_d;
         r_mem_rw    <= w_mem_rw_d;
         r_mem_bank  <= w_mem_bank_d;
         r_mem_addr  <= w_mem_addr_d;
         r_mem_wdata <= w_mem_wdata_d;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant[0])      w_state_nxt = ARB_WRITE;
            else if (w_grant[1]) w_state_nxt = ARB_READ;
         end
         ARB_WRITE:     w_state_nxt = ARB_IDLE;
         ARB_READ:      w_state_nxt = r_oor ? ARB_IDLE : ARB_READ_WAIT;
         ARB_READ_WAIT: if (r_lat_cnt == 3'(READ_LATENCY)) w_state_nxt = ARB_IDLE;
         default:       w_state_nxt = ARB_IDLE;
      endcase
   end

   // Outputs are registered, so their next values are decided on the grant edge.
   always_comb begin
      w_wr_ack_d    = 1'b0;
      w_rd_ack_d    = 1'b0;
      w_rd_valid_d  = 1'b0;
      w_err_d       = 1'b0;
      w_mem_en_d    = 1'b0;
      w_rd_data_d   = r_rd_data;
      w_mem_rw_d    = r_mem_rw;
      w_mem_bank_d  = r_mem_bank;
      w_mem_addr_d  = r_mem_addr;
      w_mem_wdata_d = r_mem_wdata;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant[0]) begin
               w_wr_ack_d = 1'b1;
               w_err_d    = w_wr_oor;
               if (!w_wr_oor) begin
                  w_mem_en_d    = 1'b1;
                  w_mem_rw_d    = 1'b1;
                  w_mem_bank_d  = wr_bank_i;
                  w_mem_addr_d  = wr_addr_i;
                  w_mem_wdata_d = wr_data_i;
               end
            end else if (w_grant[1]) begin
               if (w_rd_oor) begin
                  w_rd_ack_d = 1'b1;
                  w_err_d    = 1'b1;
               end else begin
                  w_mem_en_d   = 1'b1;
                  w_mem_rw_d   = 1'b0;
                  w_mem_bank_d = rd_bank_i;
                  w_mem_addr_d = rd_addr_i;
               end
            end
         end
         ARB_READ_WAIT: begin
            if (w_rd_capture) begin
               w_rd_data_d  = mem_rdata_i;
               w_rd_valid_d = 1'b1;
               w_rd_ack_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign wr_ack_o    = r_wr_ack;
   assign rd_ack_o    = r_rd_ack;
   assign rd_valid_o  = r_rd_valid;
   assign rd_data_o   = r_rd_data;
   assign err_o       = r_err;
   assign mem_en_o    = r_mem_en;
   assign mem_rw_o    = r_mem_rw;
   assign mem_bank_o  = r_mem_bank;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

`ifdef ARB_WAIT_STATS_EN
   logic [15:0] r_wr_wait_cnt, r_rd_wait_cnt;
   logic        w_wr_in_svc, w_rd_in_svc;

   assign w_wr_in_svc = (r_state == ARB_WRITE);
   assign w_rd_in_svc = (r_state == ARB_READ) || (r_state == ARB_READ_WAIT);

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_wait_cnt <= '0;
         r_rd_wait_cnt <= '0;
      end else if (stats_clr_i) begin
         r_wr_wait_cnt <= '0;
         r_rd_wait_cnt <= '0;
      end else begin
         if (wr_req_i && !w_wr_in_svc && r_wr_wait_cnt != 16'hFFFF) r_wr_wait_cnt <= r_wr_wait_cnt + 16'd1;
         if (rd_req_i && !w_rd_in_svc && r_rd_wait_cnt != 16'hFFFF) r_rd_wait_cnt <= r_rd_wait_cnt + 16'd1;
      end
   end

   assign wr_wait_cnt_o = r_wr_wait_cnt;
   assign rd_wait_cnt_o = r_rd_wait_cnt;
`endif

endmodule

// File: tb/tb_clip_memory_arbiter.sv
// Randomized and directed bench for clip_memory_arbiter with a behavioural memory and transaction-level requester model.
module tb_clip_memory_arbiter;

   localparam int AW = 17, DW = 8, DEPTH = 100000, RL = 2;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          wr_req_i = 1'b0, wr_bank_i = 1'b0, rd_req_i = 1'b0, rd_bank_i = 1'b0;
   logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
   logic [DW-1:0] wr_data_i = '0;
   logic [DW-1:0] mem_rdata_i;
   logic          wr_ack_o, rd_ack_o, rd_valid_o, err_o, mem_en_o, mem_rw_o, mem_bank_o;
   logic [DW-1:0] rd_data_o, mem_wdata_o;
   logic [AW-1:0] mem_addr_o;
`ifdef ARB_WAIT_STATS_EN
   logic          stats_clr_i = 1'b0;
   logic [15:0]   wr_wait_cnt_o, rd_wait_cnt_o;
`endif

   clip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
`ifdef ARB_WAIT_STATS_EN
      .stats_clr_i   (stats_clr_i),
      .wr_wait_cnt_o (wr_wait_cnt_o),
      .rd_wait_cnt_o (rd_wait_cnt_o),
`endif
      .wr_req_i    (wr_req_i),
      .wr_addr_i   (wr_addr_i),
      .wr_bank_i   (wr_bank_i),
      .wr_data_i   (wr_data_i),
      .wr_ack_o    (wr_ack_o),
      .rd_req_i    (rd_req_i),
      .rd_addr_i   (rd_addr_i),
      .rd_bank_i   (rd_bank_i),
      .rd_ack_o    (rd_ack_o),
      .rd_valid_o  (rd_valid_o),
      .rd_data_o   (rd_data_o),
      .err_o       (err_o),
      .mem_en_o    (mem_en_o),
      .mem_rw_o    (mem_rw_o),
      .mem_bank_o  (mem_bank_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clock_i = ~clock_i;

   int checks = 0, errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   logic [63:0] outs_vec;
   assign outs_vec = {24'd0, wr_ack_o, rd_ack_o, rd_valid_o, rd_data_o, err_o,
                      mem_en_o, mem_rw_o, mem_bank_o, mem_addr_o, mem_wdata_o};

   // Behavioural clip memory: unwritten locations return a fixed pattern.
   logic [7:0] mem [logic [17:0]];
   logic [7:0] hist [0:4];
   int         strobe_cnt = 0;
   bit         log_en = 0;
   int         order_q[$];
   logic [7:0] last_rd = 8'h00;

   function automatic logic [7:0] mem_read(input logic b, input logic [16:0] a);
      logic [17:0] k;
      k = {b, a};
      if (mem.exists(k)) return mem[k];
      return a[7:0] ^ 8'h5A ^ {b, 7'd0};
   endfunction

   always @(negedge clock_i) begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = 8'($urandom);
      if (mem_en_o) begin
         strobe_cnt++;
         if (log_en) order_q.push_back(mem_rw_o ? 0 : 1);
         if (mem_rw_o) mem[{mem_bank_o, mem_addr_o}] = mem_wdata_o;
         else          hist[0] = mem_read(mem_bank_o, mem_addr_o);
      end
      mem_rdata_i = hist[RL];
   end

   task automatic do_write(input logic [16:0] a, input logic b, input logic [7:0] d, input bit strict);
      int n;
      bit oor;
      n = 0;
      oor = (a >= DEPTH);
      wr_addr_i = a; wr_bank_i = b; wr_data_i = d; wr_req_i = 1'b1;
      forever begin
         @(negedge clock_i);
         n++;
         if (wr_ack_o) break;
         if (n > 60) begin
            check_eq("wr_timeout", 64'(n), 64'd0);
            wr_req_i = 1'b0;
            return;
         end
      end
      if (strict) check_eq("wr_latency", 64'(n), 64'd1);
      check_eq("wr_err", err_o, oor);
      check_eq("wr_strobe", mem_en_o, !oor);
      if (!oor) check_eq("wr_mem", {mem_rw_o, mem_bank_o, mem_addr_o, mem_wdata_o}, {1'b1, b, a, d});
      wr_req_i = 1'b0;
   endtask

   task automatic do_read(input logic [16:0] a, input logic b, input bit strict);
      int n;
      bit oor;
      logic [7:0] exp_d;
      n = 0;
      oor = (a >= DEPTH);
      exp_d = oor ? last_rd : mem_read(b, a);
      rd_addr_i = a; rd_bank_i = b; rd_req_i = 1'b1;
      forever begin
         @(negedge clock_i);
         n++;
         if (strict && n == 1) check_eq("rd_strobe", mem_en_o, !oor);
         if (strict && n == 1 && !oor) check_eq("rd_mem", {mem_rw_o, mem_bank_o, mem_addr_o}, {1'b0, b, a});
         if (rd_ack_o) break;
         if (n > 60) begin
            check_eq("rd_timeout", 64'(n), 64'd0);
            rd_req_i = 1'b0;
            return;
         end
      end
      if (strict) check_eq("rd_latency", 64'(n), oor ? 64'd1 : 64'(RL + 2));
      check_eq("rd_err", err_o, oor);
      check_eq("rd_valid", rd_valid_o, !oor);
      check_eq("rd_data", rd_data_o, exp_d);
      check_eq("rd_ack_no_strobe", mem_en_o, 1'b0);
      if (!oor) last_rd = exp_d;
      rd_req_i = 1'b0;
   endtask

   function automatic logic [16:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return 17'(DEPTH - 1);
         1:       return 17'(DEPTH);
         2:       return 17'h1FFFF;
         default: return 17'($urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   initial begin
      int nw;
      int base, legal;
      #1 reset_i = 1'b0;
      repeat (3) begin
         @(negedge clock_i);
         check_eq("reset_outs", outs_vec, 64'd0);
      end
      reset_i = 1'b1;
      @(negedge clock_i);
      check_eq("idle_no_strobe", mem_en_o, 1'b0);

      do_write(17'h00010, 1'b1, 8'hA5, 1'b1);
      @(negedge clock_i);
      check_eq("wr_pulse_one_cycle", {wr_ack_o, mem_en_o}, 2'b00);

      mem[{1'b0, 17'h00020}] = 8'h3C;
      do_read(17'h00020, 1'b0, 1'b1);
      @(negedge clock_i);
      check_eq("rd_pulse_one_cycle", {rd_ack_o, rd_valid_o}, 2'b00);
      check_eq("rd_data_held", rd_data_o, 8'h3C);

      // Both sides held busy: grants must alternate starting with the write side.
      log_en = 1;
      fork
         begin
            for (int i = 0; i < 4; i++) do_write(17'(32'h100 + i), 1'b1, 8'(i + 1), 1'b0);
         end
         begin
            for (int i = 0; i < 4; i++) do_read(17'(32'h200 + i), 1'b0, 1'b0);
         end
      join
      log_en = 0;
      check_eq("rr_count", 64'(order_q.size()), 64'd8);
      nw = 0;
      foreach (order_q[i]) begin
         check_eq($sformatf("rr_order_%0d", i), 64'(order_q[i]), 64'(i % 2));
         if (order_q[i] == 0) nw++;
      end
      check_eq("rr_writes", 64'(nw), 64'd4);
      @(negedge clock_i);

      do_write(17'(DEPTH - 1), 1'b1, 8'h77, 1'b1);
      @(negedge clock_i);
      do_read(17'(DEPTH), 1'b0, 1'b1);
      @(negedge clock_i);
      check_eq("err_one_cycle", {err_o, rd_ack_o}, 2'b00);
      do_write(17'(DEPTH), 1'b1, 8'h11, 1'b1);
      @(negedge clock_i);
      do_read(17'(DEPTH - 1), 1'b0, 1'b1);
      @(negedge clock_i);

      // Reset during READ_WAIT with a write pending behind the read.
      rd_addr_i = 17'h00030; rd_bank_i = 1'b0; rd_req_i = 1'b1;
      @(negedge clock_i);
      check_eq("rst_pre_strobe", mem_en_o, 1'b1);
      wr_addr_i = 17'h00040; wr_bank_i = 1'b1; wr_data_i = 8'hC3; wr_req_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      #1;
      check_eq("rst_mid_outs", outs_vec, 64'd0);
      repeat (2) begin
         @(negedge clock_i);
         check_eq("rst_no_ack", {rd_ack_o, rd_valid_o, mem_en_o}, 3'b000);
      end
      reset_i = 1'b1;
      last_rd = 8'h00;
      @(negedge clock_i);
      check_eq("rst_wr_first", {mem_en_o, mem_rw_o, wr_ack_o, mem_addr_o}, {3'b111, 17'h00040});
      wr_req_i = 1'b0;
      do_read(17'h00030, 1'b0, 1'b0);
      @(negedge clock_i);

      base  = strobe_cnt;
      legal = 0;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               logic [16:0] a;
               a = rand_addr();
               if (a < DEPTH) legal++;
               do_write(a, 1'b1, 8'($urandom), 1'b0);
               repeat ($urandom_range(0, 3)) @(negedge clock_i);
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               logic [16:0] a;
               a = rand_addr();
               if (a < DEPTH) legal++;
               do_read(a, 1'b0, 1'b0);
               repeat ($urandom_range(0, 3)) @(negedge clock_i);
            end
         end
      join
      repeat (2) @(negedge clock_i);
      check_eq("strobe_count", 64'(strobe_cnt - base), 64'(legal));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
